// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive sequencer: handshake FSM encoding,
// baud divider helper and the idle-timeout threshold.
package uart_pkg;

  // Handshake FSM encoding; any other value recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StClear = 2'b01,
    StDrain = 2'b10
  } rx_state_e;

  // Idle timeout threshold in 16x ticks (4 character times of 10 bits).
  localparam int unsigned TIMEOUT_TICKS = 640;

  // Clocks per 16x sample tick, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_freq, input int unsigned baud);
    return (clk_freq + 8 * baud) / (16 * baud);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO. A push while full is accepted only when a
// pop in the same cycle frees the slot; a pop while empty is ignored.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign count_o = count_q;
  // Head is forced to zero when empty so the output is defined out of reset.
  assign data_o  = empty_o ? 8'h00 : mem_q[rptr_q];

  // Storage array, written at the tail.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= data_i;
  end

  // Pointers wrap naturally; occupancy tracks push/pop balance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer for a 16x-oversampling UART receiver: sample-tick divider, 2-flop
// line synchroniser, ready/clear handshake and a byte FIFO with sticky overflow.
// Optional idle timeout output is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk_50mhz,
  input  logic                          rst_n,
  input  logic                          serial_rx_pin,
  output logic                          serial_rx_sync,
  output logic                          rx_clk_en,
  input  logic                          rx_data_ready,
  input  logic [7:0]                    rx_byte,
  output logic                          rx_clear_ready,
  input  logic                          rx_enable,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr
`ifdef UART_RX_TIMEOUT_EN
  ,
  output logic                          rx_idle_timeout
`endif
);

  localparam int unsigned Div  = uart_div(CLK_FREQ, BAUD);
  localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;

  logic [DivW-1:0] div_q;
  logic [1:0]      sync_q;
  rx_state_e       state_q;
  logic            clear_q;
  logic            overflow_q;
  logic            push, pop, drop, fifo_full, fifo_empty;

  // Sample-tick divider, held at zero while disabled.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (!rx_enable || div_q == DivW'(Div - 1)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign rx_clk_en = rx_enable && (div_q == DivW'(Div - 1));

  // Two-flop synchroniser, reset to the idle (mark) level.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], serial_rx_pin};
  end

  assign serial_rx_sync = sync_q[1];

  // A byte is offered to the FIFO only on the IDLE cycle that sees ready.
  assign push = (state_q == StIdle) && rx_data_ready;
  assign pop  = m_valid && m_ready;
  assign drop = push && fifo_full && !pop;

  // Handshake FSM: capture, one-cycle clear pulse, then wait for ready to fall.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      clear_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rx_data_ready) begin
            clear_q <= 1'b1;
            state_q <= StClear;
          end
        end
        StClear: begin
          clear_q <= 1'b0;
          state_q <= StDrain;
        end
        StDrain: begin
          if (!rx_data_ready) state_q <= StIdle;
        end
        default: begin
          clear_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rx_clear_ready = clear_q;

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n)            overflow_q <= 1'b0;
    else if (drop)         overflow_q <= 1'b1;
    else if (overflow_clr) overflow_q <= 1'b0;
  end

  assign overflow = overflow_q;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_50mhz),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (rx_byte),
    .pop_i   (pop),
    .data_o  (m_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m_valid = !fifo_empty;

`ifdef UART_RX_TIMEOUT_EN
  logic       push_acc;
  logic [9:0] to_cnt_q;
  logic       to_fired_q, to_pulse_q;

  assign push_acc = push && (!fifo_full || pop);

  // Idle timer: restarts on push or line activity, fires once per push.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q   <= '0;
      to_fired_q <= 1'b0;
      to_pulse_q <= 1'b0;
    end else begin
      to_pulse_q <= 1'b0;
      if (push_acc || !serial_rx_sync) begin
        to_cnt_q <= '0;
        if (push_acc) to_fired_q <= 1'b0;
      end else begin
        if (rx_clk_en && to_cnt_q != 10'(TIMEOUT_TICKS)) to_cnt_q <= to_cnt_q + 1'b1;
        if (to_cnt_q == 10'(TIMEOUT_TICKS) && m_valid && !to_fired_q) begin
          to_pulse_q <= 1'b1;
          to_fired_q <= 1'b1;
        end
      end
    end
  end

  assign rx_idle_timeout = to_pulse_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl (default build, timeout feature off).
// Reference model: a byte queue plus an overflow bit, updated once per cycle.
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DIV   = 27;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_rx_pin;
  logic       serial_rx_sync;
  logic       rx_clk_en;
  logic       rx_data_ready;
  logic [7:0] rx_byte;
  logic       rx_clear_ready;
  logic       rx_enable;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       overflow_clr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mdl_q[$];
  bit         mdl_ovf   = 0;
  bit         clr_prev  = 0;
  bit         rand_mode = 0;
  int         pushes    = 0;
  logic [7:0] pend_byte = 8'h00;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .CLK_FREQ   (50000000),
    .BAUD       (115200),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_50mhz      (clk),
    .rst_n          (rst_n),
    .serial_rx_pin  (serial_rx_pin),
    .serial_rx_sync (serial_rx_sync),
    .rx_clk_en      (rx_clk_en),
    .rx_data_ready  (rx_data_ready),
    .rx_byte        (rx_byte),
    .rx_clear_ready (rx_clear_ready),
    .rx_enable      (rx_enable),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr)
  );

  // One clock cycle with model update; called with inputs already driven.
  task automatic cyc();
    bit pop_e, clr_e, drop;
    if (rand_mode) begin
      m_ready      = 1'($urandom_range(0, 1));
      overflow_clr = ($urandom_range(0, 7) == 0);
    end
    n_checks++;
    if (mdl_q.size() != 0) begin
      if (m_valid !== 1'b1 || m_data !== mdl_q[0]) begin
        n_fail++;
        $display("FAIL head: m_valid=%b m_data=%h, required 1/%h", m_valid, m_data, mdl_q[0]);
      end
    end else if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_valid: m_valid=%b, required 0", m_valid);
    end
    pop_e = m_ready && (mdl_q.size() != 0);
    clr_e = overflow_clr;
    @(posedge clk);
    #1;
    if (pop_e) void'(mdl_q.pop_front());
    drop = 0;
    if (rx_clear_ready === 1'b1 && !clr_prev) begin
      pushes++;
      if (mdl_q.size() < DEPTH) mdl_q.push_back(pend_byte);
      else drop = 1;
    end
    if (drop) mdl_ovf = 1;
    else if (clr_e) mdl_ovf = 0;
    n_checks++;
    if (clr_prev && rx_clear_ready === 1'b1) begin
      n_fail++;
      $display("FAIL clear_width: rx_clear_ready high 2 cycles, required 1");
    end
    clr_prev = (rx_clear_ready === 1'b1);
    n_checks++;
    if (fifo_count !== 4'(mdl_q.size())) begin
      n_fail++;
      $display("FAIL count: fifo_count=%0d, required %0d", fifo_count, mdl_q.size());
    end
    n_checks++;
    if (overflow !== mdl_ovf) begin
      n_fail++;
      $display("FAIL overflow: overflow=%b, required %b", overflow, mdl_ovf);
    end
  endtask

  // Receiver model: raise ready, wait for the clear pulse, hold `extra` cycles.
  task automatic send_byte(input logic [7:0] b, input int extra);
    bit got;
    int p0;
    got = 0;
    p0  = pushes;
    rx_byte = b;
    pend_byte = b;
    rx_data_ready = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      cyc();
      if (clr_prev) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL clear_timeout: no rx_clear_ready within 8 cycles for byte %h", b);
    end
    repeat (extra) cyc();
    rx_data_ready = 1'b0;
    rx_byte = 8'($urandom);
    cyc();
    cyc();
    n_checks++;
    if (pushes != p0 + 1) begin
      n_fail++;
      $display("FAIL capture_once: %0d clear pulses for byte %h, required 1", pushes - p0, b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    serial_rx_pin = 1'b1;
    rx_data_ready = 1'b0;
    rx_byte = 8'h00;
    rx_enable = 1'b0;
    m_ready = 1'b0;
    overflow_clr = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({serial_rx_sync, rx_clk_en, rx_clear_ready, m_valid, overflow} !== 5'b10000 ||
        fifo_count !== 4'd0 || m_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: sync=%b clk_en=%b clr=%b valid=%b ovf=%b cnt=%0d data=%h",
               serial_rx_sync, rx_clk_en, rx_clear_ready, m_valid, overflow, fifo_count, m_data);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (rx_clear_ready !== 1'b0 || m_valid !== 1'b0 || rx_clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: clr=%b valid=%b clk_en=%b, required 0/0/0",
               rx_clear_ready, m_valid, rx_clk_en);
    end
  endtask

  task automatic test_divider();
    rx_enable = 1'b1;
    for (int n = 0; n <= 100; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      n_checks++;
      if (rx_clk_en !== ((n % DIV) == DIV - 1)) begin
        n_fail++;
        $display("FAIL tick_n%0d: rx_clk_en=%b, required %b", n, rx_clk_en, (n % DIV) == DIV - 1);
      end
    end
    rx_enable = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (rx_clk_en !== 1'b0) begin
        n_fail++;
        $display("FAIL tick_disabled_n%0d: rx_clk_en=%b, required 0", n, rx_clk_en);
      end
    end
    rx_enable = 1'b1;
  endtask

  task automatic test_sync();
    logic prev, cur;
    prev = serial_rx_pin;
    for (int n = 0; n < 40; n++) begin
      cur = 1'($urandom);
      serial_rx_pin = cur;
      @(posedge clk);
      #1;
      n_checks++;
      if (serial_rx_sync !== prev) begin
        n_fail++;
        $display("FAIL sync_lag_n%0d: serial_rx_sync=%b, required %b", n, serial_rx_sync, prev);
      end
      prev = cur;
    end
    serial_rx_pin = 1'b1;
  endtask

  task automatic test_single_byte();
    m_ready = 1'b0;
    send_byte(8'hA5, 1);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || fifo_count !== 4'd1) begin
      n_fail++;
      $display("FAIL single_byte: valid=%b data=%h cnt=%0d, required 1/a5/1",
               m_valid, m_data, fifo_count);
    end
    m_ready = 1'b1;
    repeat (3) cyc();
    m_ready = 1'b0;
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send_byte(8'(i), i % 3);
    n_checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_fill: cnt=%0d ovf=%b, required 8/1", fifo_count, overflow);
    end
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL drain_order_%0d: valid=%b data=%h, required 1/%h", i, m_valid, m_data, 8'(i));
      end
      cyc();
    end
    n_checks++;
    if (m_valid !== 1'b0 || fifo_count !== 4'd0) begin
      n_fail++;
      $display("FAIL drain_empty: valid=%b cnt=%0d, required 0/0", m_valid, fifo_count);
    end
    m_ready = 1'b0;
    overflow_clr = 1'b1;
    cyc();
    overflow_clr = 1'b0;
  endtask

  task automatic test_full_with_pop();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 0);
    rx_byte = 8'hC3;
    pend_byte = 8'hC3;
    rx_data_ready = 1'b1;
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    n_checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b0 || rx_clear_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_push_pop: cnt=%0d ovf=%b clr=%b, required 8/0/1",
               fifo_count, overflow, rx_clear_ready);
    end
    rx_data_ready = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_overflow_clr();
    rx_byte = 8'h77;
    pend_byte = 8'h77;
    rx_data_ready = 1'b1;
    overflow_clr = 1'b1;
    cyc();
    overflow_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_vs_drop: overflow=%b, required 1", overflow);
    end
    rx_data_ready = 1'b0;
    overflow_clr = 1'b1;
    cyc();
    overflow_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_alone: overflow=%b, required 0", overflow);
    end
    cyc();
  endtask

  task automatic test_reset_mid_byte();
    bit got;
    m_ready = 1'b1;
    repeat (10) cyc();
    m_ready = 1'b0;
    serial_rx_pin = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), 0);
    rx_byte = 8'h5A;
    pend_byte = 8'h5A;
    rx_data_ready = 1'b1;
    cyc();
    n_checks++;
    if (rx_clear_ready !== 1'b1 || fifo_count !== 4'd4 || serial_rx_sync !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_state: clr=%b cnt=%0d sync=%b, required 1/4/0",
               rx_clear_ready, fifo_count, serial_rx_sync);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({serial_rx_sync, rx_clk_en, rx_clear_ready, m_valid, overflow} !== 5'b10000 ||
        fifo_count !== 4'd0 || m_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: sync=%b clk_en=%b clr=%b valid=%b ovf=%b cnt=%0d data=%h",
               serial_rx_sync, rx_clk_en, rx_clear_ready, m_valid, overflow, fifo_count, m_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    serial_rx_pin = 1'b1;
    mdl_q.delete();
    mdl_ovf = 0;
    clr_prev = 0;
    cyc();
    got = clr_prev;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL pending_capture: rx_clear_ready=%b one cycle after release, required 1",
               rx_clear_ready);
    end
    rx_data_ready = 1'b0;
    cyc();
    cyc();
    n_checks++;
    if (fifo_count !== 4'd1 || m_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL post_reset_byte: cnt=%0d data=%h, required 1/5a", fifo_count, m_data);
    end
  endtask

  task automatic test_random();
    rand_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send_byte(8'($urandom), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 3)) cyc();
    end
    rand_mode = 0;
    overflow_clr = 1'b0;
    m_ready = 1'b1;
    repeat (12) cyc();
    n_checks++;
    if (m_valid !== 1'b0 || fifo_count !== 4'd0) begin
      n_fail++;
      $display("FAIL random_drain: valid=%b cnt=%0d, required 0/0", m_valid, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_sync();
    test_single_byte();
    test_overflow();
    test_full_with_pop();
    test_overflow_clr();
    test_reset_mid_byte();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Sequencer for the 16x-oversampling UART receiver. Generates the receiver's sample-enable tick and 2-flop-synchronises the serial line.
- Runs the receiver's ready/clear handshake and drains each received byte into a small FIFO.
- Presents the FIFO as a valid/ready byte stream with overflow status. Sits between the pin/receiver pair and the consuming logic.

Parameters:
- CLK_FREQ, 50000000: system clock in Hz.
- BAUD, 115200: line rate.
- FIFO_DEPTH, 8: byte entries, power of two, at least 2.

Ports:
- clk_50mhz  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- serial_rx_pin  in  1  raw asynchronous line.
- serial_rx_sync  out  1  synchronised line to the receiver.
- rx_clk_en  out  1  one-cycle 16x sample tick to the receiver.
- rx_data_ready  in  1  receiver byte-available flag.
- rx_byte  in  8  receiver data.
- rx_clear_ready  out  1  clear pulse to the receiver.
- rx_enable  in  1  gates tick generation.
- m_data  out  8  FIFO head byte.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky, set when a byte is dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset (async assert, sync release):
  - serial_rx_sync is 1 (line idle) and both sync flops are 1.
  - rx_clk_en, rx_clear_ready, m_valid and overflow are 0.
  - fifo_count is 0, m_data is 0, the divider is 0 and the FSM is IDLE.
- Divider:
  - DIV = (CLK_FREQ + 8*BAUD) / (16*BAUD), rounded; 27 at the defaults.
  - The counter counts 0..DIV-1 while rx_enable=1.
  - rx_clk_en pulses high for exactly one cycle when the counter is at DIV-1, then the counter wraps to 0.
  - rx_enable=0 holds the counter at 0 and keeps rx_clk_en at 0.
- Synchroniser: 2 flops, so serial_rx_sync lags serial_rx_pin by 2 cycles.
- Handshake FSM states: IDLE, CLEAR, DRAIN.
  - IDLE: on rx_data_ready=1, write rx_byte into the FIFO.
    - If the FIFO is full after this cycle's read, drop the byte and set overflow instead.
    - Assert rx_clear_ready and move to CLEAR.
  - CLEAR: rx_clear_ready is high for exactly 1 cycle. Then deassert it and go to DRAIN.
  - DRAIN: return to IDLE once rx_data_ready=0. This makes each byte captured exactly once.
  - Encoding 2'b00/01/10. Any other encoding returns to IDLE.
- FIFO:
  - First-word fall-through: m_data is valid whenever m_valid=1.
  - A pop occurs when m_valid && m_ready.
  - A simultaneous push and pop while full is allowed: the pop frees the slot, so the byte is not dropped and fifo_count is unchanged.
  - A pop while empty is ignored.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- overflow:
  - overflow_clr and a new drop in the same cycle leave overflow at 1 (set wins).
- Reset mid-byte: FIFO contents are lost and the FSM returns to IDLE. A receiver byte left pending is captured after reset release.

Optional Feature:
- Macro UART_RX_TIMEOUT_EN.
- When defined:
  - Adds output rx_idle_timeout (1 bit).
  - A counter of rx_clk_en ticks resets on every FIFO push and on every serial_rx_sync low.
  - When it reaches 640 ticks (4 character times) with m_valid=1, rx_idle_timeout pulses for 1 cycle.
  - It does not re-fire until the next push.
- When undefined: the port and counter are absent.

Decomposition:
- Package uart_pkg holds:
  - the FSM state encoding constants;
  - a uart_div function computing DIV from CLK_FREQ and BAUD;
  - the constant TIMEOUT_TICKS = 640.
- Sub-module uart_rx_fifo (parameter DEPTH): synchronous FWFT FIFO with push, pop, full, empty and count, same clock and rst_n.

Test Plan:
1. Reset then rx_enable=1 at defaults -> rx_clk_en pulses every 27 cycles, width 1. Drop rx_enable -> no pulses.
2. Receiver model asserts rx_data_ready with rx_byte=8'hA5 -> rx_clear_ready high 1 cycle, then m_valid=1, m_data=8'hA5, fifo_count=1. The model holding ready for one extra cycle causes no duplicate push.
3. m_ready=0 while 9 bytes 8'h01..8'h09 arrive -> fifo_count=8, overflow=1, byte 8'h09 dropped. Draining yields 8'h01..8'h08 in order.
4. FIFO full with m_ready=1 at the same cycle a new byte arrives -> byte accepted, overflow stays 0, fifo_count stays 8.
5. overflow_clr asserted in the same cycle as a drop -> overflow stays 1. overflow_clr alone on the next cycle -> 0.
6. rst_n low while in CLEAR with 3 bytes queued -> all outputs take their reset values immediately (asynchronously). After release the FSM is in IDLE and fifo_count=0.
